cirno_lsu: RTL and testbench

Load/store stage directly downstream of the execute stage. Accepts one memory request per handshake, drives a single-outstanding request/grant/response data bus, and returns load data with its destination register index to writeback through a valid/ready handshake. Non-pipelined: one transaction in flight; execute is back-pressured until it retires.

---
 rtl/cirno_lsu.sv | 142 ++++++++++++++
 tb/tb_cirno_lsu.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cirno_lsu.sv
// cirno_lsu: non-pipelined load/store stage between execute and writeback.
// It accepts one request at a time from execute and drives a single-outstanding
// req/gnt/rvld data bus. Load data is returned to writeback through a
// valid/ready handshake. A WAIT phase that lasts TIMEOUT cycles aborts with a
// bus error pulse.
// Optional feature: define CIRNO_LSU_MISALIGN_CHK_EN to reject requests with
// adr[1:0] != 0. A rejected load returns 0 and a rejected store is dropped.
// When the macro is not defined, the low address bits are ignored.
module cirno_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_ex4mem_val,
  output logic        hs_mem4ex_rdy,
  input  logic [31:0] i_mem_adr,
  input  logic [31:0] i_mem_d,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [4:0]  i_rd_idx,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic [31:0] o_bus_adr,
  output logic [31:0] o_bus_wdat,
  output logic        o_bus_we,
  input  logic        i_bus_rvld,
  input  logic [31:0] i_bus_rdat,
  output logic        hs_mem4wb_val,
  input  logic        hs_wb4mem_rdy,
  output logic [4:0]  o_wb_rd_idx,
  output logic [31:0] o_wb_rd,
  output logic        o_bus_err
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
  ,
  output logic        o_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // The last WAIT cycle that can still accept a response has counter value
  // TIMEOUT-1. If no response arrives by then, the FSM leaves WAIT exactly
  // TIMEOUT cycles after it entered.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        bad_align;

`ifdef CIRNO_LSU_MISALIGN_CHK_EN
  assign bad_align = (i_mem_adr[1:0] != 2'b00);
`else
  logic unused_adr_lo;
  assign unused_adr_lo = ^i_mem_adr[1:0];
  assign bad_align     = 1'b0;
`endif

  // Transaction FSM. All outputs are registered here, so no input path
  // reaches a bus output combinationally.
  // NOTE: sequential state uses nonblocking (<=) assignments only. This keeps
  // every flop sampling the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      hs_mem4ex_rdy <= 1'b1;
      o_bus_req     <= 1'b0;
      o_bus_adr     <= '0;
      o_bus_wdat    <= '0;
      o_bus_we      <= 1'b0;
      hs_mem4wb_val <= 1'b0;
      o_wb_rd       <= '0;
      o_wb_rd_idx   <= '0;
      o_bus_err     <= 1'b0;
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
      o_misalign    <= 1'b0;
`endif
    end else begin
      o_bus_err <= 1'b0;
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
      o_misalign <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          // A request with neither ren nor wen is consumed without bus activity.
          if (hs_ex4mem_val && (i_mem_wen || i_mem_ren)) begin
            o_bus_adr   <= {i_mem_adr[31:2], 2'b00};
            o_bus_wdat  <= i_mem_d;
            o_bus_we    <= i_mem_wen;
            o_wb_rd_idx <= i_rd_idx;
            if (bad_align) begin
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
              o_misalign <= 1'b1;
`endif
              // A misaligned store is dropped. A misaligned load returns zero.
              if (!i_mem_wen) begin
                o_wb_rd       <= '0;
                hs_mem4wb_val <= 1'b1;
                hs_mem4ex_rdy <= 1'b0;
                state         <= RESP;
              end
            end else begin
              o_bus_req     <= 1'b1;
              hs_mem4ex_rdy <= 1'b0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (i_bus_rvld || cnt == CNT_LAST) begin
            o_bus_err <= !i_bus_rvld;
            if (o_bus_we) begin
              hs_mem4ex_rdy <= 1'b1;
              state         <= IDLE;
            end else begin
              o_wb_rd       <= i_bus_rvld ? i_bus_rdat : 32'h0000_0000;
              hs_mem4wb_val <= 1'b1;
              state         <= RESP;
            end
          end
        end
        RESP: begin
          if (hs_wb4mem_rdy) begin
            hs_mem4wb_val <= 1'b0;
            hs_mem4ex_rdy <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cirno_lsu.sv
// tb_cirno_lsu: randomized self-checking bench for cirno_lsu.
// Each transaction is planned as a cycle-by-cycle timeline derived from the
// handshake rules: accept, grant delay, response delay or timeout, and
// writeback stall. The expected outputs for each cycle are queued, and a
// compare process checks them on every falling edge.
module tb_cirno_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_ex4mem_val;
  logic        hs_mem4ex_rdy;
  logic [31:0] i_mem_adr;
  logic [31:0] i_mem_d;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [4:0]  i_rd_idx;
  logic        o_bus_req;
  logic        i_bus_gnt;
  logic [31:0] o_bus_adr;
  logic [31:0] o_bus_wdat;
  logic        o_bus_we;
  logic        i_bus_rvld;
  logic [31:0] i_bus_rdat;
  logic        hs_mem4wb_val;
  logic        hs_wb4mem_rdy;
  logic [4:0]  o_wb_rd_idx;
  logic [31:0] o_wb_rd;
  logic        o_bus_err;
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
  logic        o_misalign;
`endif

  always #5 clk = ~clk;

  cirno_lsu #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .hs_ex4mem_val (hs_ex4mem_val),
    .hs_mem4ex_rdy (hs_mem4ex_rdy),
    .i_mem_adr     (i_mem_adr),
    .i_mem_d       (i_mem_d),
    .i_mem_ren     (i_mem_ren),
    .i_mem_wen     (i_mem_wen),
    .i_rd_idx      (i_rd_idx),
    .o_bus_req     (o_bus_req),
    .i_bus_gnt     (i_bus_gnt),
    .o_bus_adr     (o_bus_adr),
    .o_bus_wdat    (o_bus_wdat),
    .o_bus_we      (o_bus_we),
    .i_bus_rvld    (i_bus_rvld),
    .i_bus_rdat    (i_bus_rdat),
    .hs_mem4wb_val (hs_mem4wb_val),
    .hs_wb4mem_rdy (hs_wb4mem_rdy),
    .o_wb_rd_idx   (o_wb_rd_idx),
    .o_wb_rd       (o_wb_rd),
    .o_bus_err     (o_bus_err)
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
    ,
    .o_misalign    (o_misalign)
`endif
  );

  typedef struct {
    int          cyc;
    logic        rdy, req, we, wbval, err, mis;
    logic [31:0] adr, wdat, wbrd;
    logic [4:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   err_cyc = -1;
  int   mis_cyc = -1;

  // Observations used by the hand-computed literal checks.
  int          first_val_cyc = -1;
  int          first_err_cyc = -1;
  logic [31:0] first_wb_rd = '0;
  int          req_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t base();
    exp_t e;
    e.cyc = 0; e.rdy = 1'b1; e.req = 1'b0; e.we = 1'b0; e.wbval = 1'b0;
    e.err = 1'b0; e.mis = 1'b0; e.adr = '0; e.wdat = '0; e.wbrd = '0; e.idx = '0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    exp_t x;
    x = e;
    x.cyc = cyc;
    x.err = (cyc == err_cyc);
    x.mis = (cyc == mis_cyc);
    exp_q.push_back(x);
  endtask

  task automatic next_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Random input traffic that the DUT must ignore in its current phase.
  task automatic junk();
    hs_ex4mem_val = 1'($urandom);
    i_mem_adr     = $urandom;
    i_mem_d       = $urandom;
    i_mem_ren     = 1'($urandom);
    i_mem_wen     = 1'($urandom);
    i_rd_idx      = 5'($urandom);
    i_bus_gnt     = 1'($urandom);
    i_bus_rvld    = 1'($urandom);
    i_bus_rdat    = $urandom;
    hs_wb4mem_rdy = 1'($urandom);
  endtask

  task automatic idle_cycle();
    junk();
    hs_ex4mem_val = 1'b0;
    push(base());
    next_cycle();
  endtask

  // Writeback phase: valid held for s stalled cycles, accepted on cycle s.
  task automatic resp(input logic [4:0] idx, input logic [31:0] data, input int s);
    exp_t e;
    for (int i = 0; i <= s; i++) begin
      junk();
      hs_wb4mem_rdy = (i == s);
      e = base(); e.rdy = 1'b0; e.wbval = 1'b1; e.wbrd = data; e.idx = idx;
      push(e);
      next_cycle();
    end
  endtask

  // One transaction. g is the grant delay in REQ cycles. r is the response
  // delay in WAIT cycles (r >= TO means no response). s is the writeback stall.
  task automatic run_txn(input bit ren, input bit wen, input logic [31:0] adr,
                         input logic [31:0] d, input logic [4:0] idx,
                         input int g, input int r, input int s, input logic [31:0] rdat);
    exp_t e;
    bit   mis;
    bit   tmo;
    int   wait_n;
    mis = 1'b0;
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
    mis = (adr[1:0] != 2'b00);
`endif
    junk();
    hs_ex4mem_val = 1'b1; i_mem_ren = ren; i_mem_wen = wen;
    i_mem_adr = adr; i_mem_d = d; i_rd_idx = idx;
    push(base());
    next_cycle();
    if (!ren && !wen) return;
    if (mis) begin
      mis_cyc = cyc;
      if (!wen) resp(idx, 32'h0, s);
      return;
    end
    for (int i = 0; i <= g; i++) begin
      junk();
      i_bus_gnt = (i == g);
      e = base(); e.rdy = 1'b0; e.req = 1'b1;
      e.adr = {adr[31:2], 2'b00}; e.wdat = d; e.we = wen;
      push(e);
      next_cycle();
    end
    tmo    = (r >= TO);
    wait_n = tmo ? TO : r + 1;
    for (int i = 0; i < wait_n; i++) begin
      junk();
      i_bus_rvld = !tmo && (i == r);
      if (i == r) i_bus_rdat = rdat;
      e = base(); e.rdy = 1'b0;
      push(e);
      next_cycle();
    end
    if (tmo) err_cyc = cyc;
    if (!wen) resp(idx, tmo ? 32'h0 : rdat, s);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},   hs_mem4ex_rdy, 1'b1);
    check({tag, "_req"},   o_bus_req, 1'b0);
    check({tag, "_we"},    o_bus_we, 1'b0);
    check({tag, "_adr"},   o_bus_adr, 32'h0);
    check({tag, "_wdat"},  o_bus_wdat, 32'h0);
    check({tag, "_wbval"}, hs_mem4wb_val, 1'b0);
    check({tag, "_wbrd"},  o_wb_rd, 32'h0);
    check({tag, "_wbidx"}, o_wb_rd_idx, 5'd0);
    check({tag, "_err"},   o_bus_err, 1'b0);
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
    check({tag, "_mis"},   o_misalign, 1'b0);
`endif
  endtask

  // Compare process: checks DUT outputs against the queued expectation for
  // every planned cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rdy", hs_mem4ex_rdy, e.rdy);
      check("bus_req", o_bus_req, e.req);
      if (e.req) begin
        check("bus_adr", o_bus_adr, e.adr);
        check("bus_wdat", o_bus_wdat, e.wdat);
        check("bus_we", o_bus_we, e.we);
      end
      check("wb_val", hs_mem4wb_val, e.wbval);
      if (e.wbval) begin
        check("wb_rd", o_wb_rd, e.wbrd);
        check("wb_idx", o_wb_rd_idx, e.idx);
      end
      check("bus_err", o_bus_err, e.err);
`ifdef CIRNO_LSU_MISALIGN_CHK_EN
      check("misalign", o_misalign, e.mis);
`endif
      if (hs_mem4wb_val && first_val_cyc < 0) begin
        first_val_cyc = e.cyc;
        first_wb_rd   = o_wb_rd;
      end
      if (o_bus_err && first_err_cyc < 0) first_err_cyc = e.cyc;
      if (o_bus_req) req_cnt++;
    end
  end

  initial begin
    int acc;
    int req0;
    int k;
    exp_t e;
    rst = 1'b1;
    hs_ex4mem_val = 1'b0; i_mem_adr = '0; i_mem_d = '0; i_mem_ren = 1'b0;
    i_mem_wen = 1'b0; i_rd_idx = '0; i_bus_gnt = 1'b0; i_bus_rvld = 1'b0;
    i_bus_rdat = '0; hs_wb4mem_rdy = 1'b0;
    #2;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // Directed load: gnt at once, response next cycle, result 3 cycles after accept.
    first_val_cyc = -1;
    acc = cyc;
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 0, 0, 0, 32'hDEADBEEF);
    idle_cycle();
    check("load_latency", 32'(first_val_cyc - acc), 32'd3);
    check("load_data", first_wb_rd, 32'hDEADBEEF);

    // Directed store: grant delayed 4 cycles, so bus_req is held for 5 cycles.
    req0 = req_cnt;
    run_txn(1'b0, 1'b1, 32'h204, 32'h12345678, 5'd0, 4, 0, 0, 32'h0);
    idle_cycle();
    check("store_req_cycles", 32'(req_cnt - req0), 32'd5);

    // Directed writeback stall for 3 cycles.
    run_txn(1'b1, 1'b0, 32'h40, 32'h0, 5'd9, 0, 1, 3, 32'hCAFEF00D);

    // Directed timeout: error pulse TO cycles after WAIT entry (accept+2), data 0.
    first_val_cyc = -1; first_err_cyc = -1;
    acc = cyc;
    run_txn(1'b1, 1'b0, 32'h80, 32'h0, 5'd3, 0, TO, 0, 32'h0);
    idle_cycle();
    check("tmo_err_cycle", 32'(first_err_cyc - acc), 32'(2 + TO));
    check("tmo_data", first_wb_rd, 32'h0);

`ifdef CIRNO_LSU_MISALIGN_CHK_EN
    // A misaligned load makes no bus request and returns zero.
    first_val_cyc = -1;
    req0 = req_cnt;
    run_txn(1'b1, 1'b0, 32'h102, 32'h0, 5'd4, 0, 0, 0, 32'h11111111);
    idle_cycle();
    check("mis_no_req", 32'(req_cnt - req0), 32'd0);
    check("mis_data", first_wb_rd, 32'h0);
`endif

    // Randomized transactions.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      run_txn(k == 1 || (k >= 2 && k <= 5), k == 1 || k >= 6, $urandom, $urandom,
              5'($urandom), $urandom_range(0, 4), $urandom_range(0, 5),
              $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset in the middle of WAIT; a late response must be ignored.
    hs_ex4mem_val = 1'b1; i_mem_ren = 1'b1; i_mem_wen = 1'b0;
    i_mem_adr = 32'h300; i_mem_d = 32'h55AA55AA; i_rd_idx = 5'd7;
    i_bus_gnt = 1'b0; i_bus_rvld = 1'b0; hs_wb4mem_rdy = 1'b1;
    push(base());
    next_cycle();
    hs_ex4mem_val = 1'b0; i_bus_gnt = 1'b1;
    e = base(); e.rdy = 1'b0; e.req = 1'b1; e.adr = 32'h300; e.wdat = 32'h55AA55AA;
    push(e);
    next_cycle();
    i_bus_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_wait");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    i_bus_rvld = 1'b1; i_bus_rdat = 32'hBAD0BAD0;
    push(base());
    next_cycle();
    i_bus_rvld = 1'b0;
    push(base());
    next_cycle();
    push(base());
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
